// File: rtl/rgb_led_mode_ctrl.sv
// rgb_led_mode_ctrl: button-stepped LED brightness controller.
// Each btn_pe press advances the mode: off, LEVELS static levels, then party mode
// where every channel fades as an independent triangle wave. All channels share
// one prescaled PWM period counter; duties are latched only on period wrap so an
// output never sees a partial-period glitch.
// Optional build macro LED_GAMMA_EN: square-law correction on the latched duty.
module rgb_led_mode_ctrl #(
   parameter int unsigned CH        = 3,
   parameter int unsigned PWM_BITS  = 10,
   parameter int unsigned PRESC     = 100,
   parameter int unsigned LEVELS    = 3,
   parameter int unsigned FADE_STEP = 8,
   localparam int unsigned MW       = $clog2(LEVELS + 2)
) (
   input  logic          clk,
   input  logic          reset_p,
   input  logic          btn_pe,
   output logic [CH-1:0] pwm_out,
   output logic [MW-1:0] mode,
   output logic          party_mode_flag
);

   localparam int unsigned   PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int unsigned   DW        = PWM_BITS + 1;
   localparam logic [DW-1:0] FS        = {1'b1, {PWM_BITS{1'b0}}};
   localparam logic [MW-1:0] PARTY     = MW'(LEVELS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic                tick, wrap;
   logic [MW-1:0]       mode_q, mode_d;
   logic                party;
   logic [DW-1:0]       fade_q [CH];
   logic [DW-1:0]       fade_d [CH];
   logic [CH-1:0]       dir_q, dir_d;   // 1 = fading down
   logic [DW-1:0]       tgt    [CH];
   logic [DW-1:0]       lat    [CH];
   logic [DW-1:0]       act_q  [CH];
   logic [CH-1:0]       pwm_q, pwm_d;

   // Static level k maps to floor(k*FS/LEVELS); folds to a constant per k.
   function automatic logic [DW-1:0] level_duty(input int unsigned k);
      return DW'((k << PWM_BITS) / LEVELS);
   endfunction

   // Per-channel fade increment: channel c moves FADE_STEP*(c+1) per period.
   function automatic logic [31:0] step_of(input int unsigned c);
      return 32'(FADE_STEP * (c + 1));
   endfunction

   // Prescaler, period counter and mode sequencing next-state.
   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + PW'(1);
      cnt_d   = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
      wrap    = tick && (cnt_q == '1);
      party   = (mode_q == PARTY);
      mode_d  = mode_q;
      if (btn_pe) begin
         mode_d = (mode_q == PARTY) ? '0 : mode_q + MW'(1);
      end
   end

   // Timebase and mode registers.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         presc_q <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Triangle fade per channel; held cleared whenever party mode is not active,
   // so entry into party always starts from 0/up.
   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         fade_d[c] = fade_q[c];
         dir_d[c]  = dir_q[c];
         if (!party) begin
            fade_d[c] = '0;
            dir_d[c]  = 1'b0;
         end else if (wrap) begin
            if (!dir_q[c]) begin
               if (32'(fade_q[c]) + step_of(c) >= 32'(FS)) begin
                  fade_d[c] = FS;
                  dir_d[c]  = 1'b1;
               end else begin
                  fade_d[c] = fade_q[c] + DW'(step_of(c));
               end
            end else begin
               if (32'(fade_q[c]) <= step_of(c)) begin
                  fade_d[c] = '0;
                  dir_d[c]  = 1'b0;
               end else begin
                  fade_d[c] = fade_q[c] - DW'(step_of(c));
               end
            end
         end
      end
   end

   // Fade state registers.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         for (int unsigned c = 0; c < CH; c++) begin
            fade_q[c] <= '0;
         end
         dir_q <= '0;
      end else begin
         for (int unsigned c = 0; c < CH; c++) begin
            fade_q[c] <= fade_d[c];
         end
         dir_q <= dir_d;
      end
   end

   // Target duty selected by the current mode.
   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         tgt[c] = '0;
         if (party) begin
            tgt[c] = fade_q[c];
         end else begin
            for (int unsigned k = 1; k <= LEVELS; k++) begin
               if (mode_q == MW'(k)) begin
                  tgt[c] = level_duty(k);
               end
            end
         end
      end
   end

`ifdef LED_GAMMA_EN
   logic [2*DW-1:0] sq [CH];

   // Square-law correction: (t*t) >> PWM_BITS keeps 0 -> 0 and FS -> FS.
   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         sq[c]  = (2*DW)'(tgt[c]) * (2*DW)'(tgt[c]);
         lat[c] = DW'(sq[c] >> PWM_BITS);
      end
   end
`else
   // Linear build: latched duty is the target itself.
   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         lat[c] = tgt[c];
      end
   end
`endif

   // Comparator: counter is zero-extended so duty FS keeps the output high all period.
   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         pwm_d[c] = ({1'b0, cnt_q} < act_q[c]);
      end
   end

   // Active duty latched on period wrap; registered PWM outputs.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         for (int unsigned c = 0; c < CH; c++) begin
            act_q[c] <= '0;
         end
         pwm_q <= '0;
      end else begin
         if (wrap) begin
            for (int unsigned c = 0; c < CH; c++) begin
               act_q[c] <= lat[c];
            end
         end
         pwm_q <= pwm_d;
      end
   end

   assign pwm_out         = pwm_q;
   assign mode            = mode_q;
   assign party_mode_flag = party;

endmodule

// File: tb/tb_rgb_led_mode_ctrl.sv
// Directed bench for rgb_led_mode_ctrl: CH=3, PWM_BITS=4, LEVELS=3, FADE_STEP=1.
// Main DUT uses PRESC=1 (16-clk period); a second instance uses PRESC=4 (64 clk).
// Expected high times are hand-derived; gam() applies the LED_GAMMA_EN mapping.
module tb_rgb_led_mode_ctrl;

   logic       clk;
   logic       reset_p;
   logic       btn, btn4;
   logic [2:0] pwm, pwm4;
   logic [2:0] mode, mode4;
   logic       flag, flag4;

   int cyc;
   int n_err;
   int n_chk;
   int hi [3];
   int hi4;

   // Fade high times for consecutive periods after entering party mode.
   int exp_fade [10][3] = '{
      '{0, 0, 0}, '{1, 2, 3}, '{2, 4, 6}, '{3, 6, 9}, '{4, 8, 12},
      '{5, 10, 15}, '{6, 12, 16}, '{7, 14, 13}, '{8, 16, 10}, '{9, 14, 7}
   };

   rgb_led_mode_ctrl #(
      .CH(3), .PWM_BITS(4), .PRESC(1), .LEVELS(3), .FADE_STEP(1)
   ) u_dut (
      .clk(clk), .reset_p(reset_p), .btn_pe(btn),
      .pwm_out(pwm), .mode(mode), .party_mode_flag(flag)
   );

   rgb_led_mode_ctrl #(
      .CH(3), .PWM_BITS(4), .PRESC(4), .LEVELS(3), .FADE_STEP(1)
   ) u_dut4 (
      .clk(clk), .reset_p(reset_p), .btn_pe(btn4),
      .pwm_out(pwm4), .mode(mode4), .party_mode_flag(flag4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gam(input int x);
`ifdef LED_GAMMA_EN
      return (x * x) >> 4;
`else
      return x;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: inputs change and outputs are sampled on the falling edge.
   task automatic clk1();
      @(negedge clk);
      cyc++;
   endtask

   task automatic press();
      btn = 1'b1;
      clk1();
      btn = 1'b0;
   endtask

   // Align to a period wrap, then count high clocks over one full period.
   task automatic run_period(input int len);
      while (cyc % len != 0) clk1();
      for (int c = 0; c < 3; c++) hi[c] = 0;
      hi4 = 0;
      repeat (len) begin
         clk1();
         for (int c = 0; c < 3; c++) hi[c] += int'(pwm[c]);
         hi4 += int'(pwm4[0]);
      end
   endtask

   task automatic chk_hi(input string tag, input int e0, input int e1, input int e2);
      chk({tag, ".ch0"}, hi[0], gam(e0));
      chk({tag, ".ch1"}, hi[1], gam(e1));
      chk({tag, ".ch2"}, hi[2], gam(e2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_err   = 0;
      n_chk   = 0;
      cyc     = 0;
      btn     = 1'b0;
      btn4    = 1'b0;
      reset_p = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.mode", mode, 0);
      chk("rst.flag", flag, 0);
      chk("rst.pwm", pwm, 0);
      reset_p = 1'b0;
      cyc = 0;

      // Idle after reset: outputs stay low.
      for (int p = 0; p < 3; p++) begin
         run_period(16);
         chk_hi("off", 0, 0, 0);
      end

      // Static levels 5/16, 10/16, 16/16.
      press();
      chk("p1.mode", mode, 1);
      chk("p1.flag", flag, 0);
      run_period(16);
      chk_hi("lvl1", 5, 5, 5);
      press();
      chk("p2.mode", mode, 2);
      run_period(16);
      chk_hi("lvl2", 10, 10, 10);
      press();
      chk("p3.mode", mode, 3);
      run_period(16);
      chk_hi("lvl3", 16, 16, 16);

      // Party mode fades.
      press();
      chk("p4.mode", mode, 4);
      chk("p4.flag", flag, 1);
      for (int p = 0; p < 10; p++) begin
         run_period(16);
         chk_hi($sformatf("fade%0d", p), exp_fade[p][0], exp_fade[p][1], exp_fade[p][2]);
      end

      // Leave party: off after next wrap.
      press();
      chk("p5.mode", mode, 0);
      chk("p5.flag", flag, 0);
      run_period(16);
      chk_hi("off2", 0, 0, 0);
      press();
      chk("p6.mode", mode, 1);
      run_period(16);
      chk_hi("lvl1b", 5, 5, 5);

      // Re-enter party: fade restarts from 0/up.
      press();
      press();
      press();
      chk("re.mode", mode, 4);
      chk("re.flag", flag, 1);
      run_period(16);
      chk_hi("refade0", 0, 0, 0);
      run_period(16);
      chk_hi("refade1", 1, 2, 3);

      // Press coinciding with a wrap: old duty one more period.
      press();
      chk("lv.mode", mode, 0);
      run_period(16);
      chk_hi("off3", 0, 0, 0);
      repeat (15) clk1();
      press();
      chk("sim.mode", mode, 1);
      run_period(16);
      chk_hi("sim.old", 0, 0, 0);
      run_period(16);
      chk_hi("sim.new", 5, 5, 5);

      // Asynchronous reset mid-period while outputs are high.
      repeat (3) clk1();
      chk("pre.pwm", pwm, (gam(5) > 2) ? 7 : 0);
      reset_p = 1'b1;
      #1;
      chk("mid.pwm", pwm, 0);
      chk("mid.mode", mode, 0);
      chk("mid.flag", flag, 0);
      repeat (2) @(negedge clk);
      reset_p = 1'b0;
      cyc = 0;

      // PRESC=4 instance: 64-clk period, level 1.
      btn4 = 1'b1;
      clk1();
      btn4 = 1'b0;
      chk("pr4.mode", mode4, 1);
      chk("pr4.flag", flag4, 0);
      run_period(64);
      chk("pr4.hi.a", hi4, gam(5) * 4);
      chk_hi("pr4.main", 0, 0, 0);
      run_period(64);
      chk("pr4.hi.b", hi4, gam(5) * 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
